// File: rtl/multi_beat_sequencer_pkg.sv
// Shared types for the multi-beat CPU control sequencer.
// Holds the state enum, fault codes and instruction-type encodings.
// Pure declarations; no logic, no latency, no backpressure.
package multi_beat_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_FETCH          = 4'd0,
        ST_FETCH_WAIT     = 4'd1,
        ST_DECODE         = 4'd2,
        ST_LOAD_MEM       = 4'd3,
        ST_LOAD_MEM_WAIT  = 4'd4,
        ST_STORE_MEM      = 4'd5,
        ST_STORE_MEM_WAIT = 4'd6,
        ST_ALU_EXEC       = 4'd7,
        ST_UPDATE_PC      = 4'd8,
        ST_IRQ_ENTRY      = 4'd9,
        ST_HALT           = 4'd10,
        ST_FAULT          = 4'd11
    } seq2_state_t;

    localparam logic [1:0] FAULT_ILLEGAL   = 2'b00;
    localparam logic [1:0] FAULT_FETCH_TO  = 2'b01;
    localparam logic [1:0] FAULT_LOAD_TO   = 2'b10;
    localparam logic [1:0] FAULT_STORE_TO  = 2'b11;

    localparam logic [1:0] INST_F = 2'b00;
    localparam logic [1:0] INST_J = 2'b01;
    localparam logic [1:0] INST_R = 2'b10;
    localparam logic [1:0] INST_I = 2'b11;

    localparam logic [1:0] IMM_LD  = 2'b00;
    localparam logic [1:0] IMM_ST  = 2'b01;
    localparam logic [1:0] IMM_LDI = 2'b10;
    localparam logic [1:0] IMM_RSV = 2'b11;

    // True for the three states that wait on the memory controller
    function automatic logic is_wait_state(input seq2_state_t s);
        return (s == ST_FETCH_WAIT) || (s == ST_LOAD_MEM_WAIT) || (s == ST_STORE_MEM_WAIT);
    endfunction

endpackage

// File: rtl/multi_beat_sequencer_wait_timer.sv
// Wait-state timer: counts cycles spent waiting, flags the last allowed cycle.
// Terminal count is combinational from the registered count (0 cycles added).
// No backpressure; clear has priority over enable.
module multi_beat_sequencer_wait_timer #(
    parameter int WIDTH    = 1,
    parameter int TERMINAL = 0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic tc_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: zero while not waiting, count up while waiting
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = en_i && (cnt_q == WIDTH'(TERMINAL));

endmodule

// File: rtl/multi_beat_sequencer.sv
// Control sequencer: fetch/decode/execute/update-PC with multi-beat fetch, timeouts, IRQ, debug halt.
// One state per cycle; all transitions registered, outputs decoded from state.
// Waits on memory via *_WAIT states; optional timeout forces FAULT.
module multi_beat_sequencer
    import multi_beat_sequencer_pkg::*;
#(
    parameter int FETCH_BEATS    = 1,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int ILLEGAL_TRAP   = 1
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        mem_busy_in,
    input  logic        inst_fetch_done_in,
    input  logic        data_read_done_in,
    input  logic [1:0]  inst_type_in,
    input  logic [1:0]  imm_type_in,
    input  logic        irq_in,
    input  logic        irq_en_in,
    input  logic        halt_req_in,
    input  logic        step_in,
    input  logic        fault_clear_in,
    output seq2_state_t seq_state_out,
    output logic [1:0]  fetch_beat_out,
    output logic        retire_out,
    output logic        irq_ack_out,
    output logic        halted_out,
    output logic        fault_out,
    output logic [1:0]  fault_code_out
);

    localparam logic [1:0] LAST_BEAT = 2'(FETCH_BEATS - 1);

    seq2_state_t state_q, state_d;
    logic [1:0]  beat_q, beat_d;
    logic        step_q, step_d;
    logic [1:0]  code_q, code_d;
    logic        in_wait;
    logic        timeout;

    assign in_wait = is_wait_state(state_q);

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timer
            multi_beat_sequencer_wait_timer #(
                .WIDTH    ($clog2(TIMEOUT_CYCLES + 1)),
                .TERMINAL (TIMEOUT_CYCLES - 1)
            ) u_wait_timer (
                .clk_i   (clk_in),
                .rst_i   (reset_in),
                .clear_i (!in_wait),
                .en_i    (in_wait),
                .tc_o    (timeout)
            );
        end else begin : g_no_timer
            assign timeout = 1'b0;
        end
    endgenerate

    // State, beat index, step flag and fault code registers
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q <= ST_FETCH;
            beat_q  <= 2'b00;
            step_q  <= 1'b0;
            code_q  <= FAULT_ILLEGAL;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            step_q  <= step_d;
            code_q  <= code_d;
        end
    end

    // Next-state logic; completion is checked before timeout so a late done still wins
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        step_d  = step_q;
        code_d  = code_q;
        case (state_q)
            ST_FETCH: state_d = ST_FETCH_WAIT;
            ST_FETCH_WAIT: begin
                if (inst_fetch_done_in) begin
                    if (beat_q < LAST_BEAT) begin
                        beat_d  = beat_q + 2'd1;
                        state_d = ST_FETCH;
                    end else begin
                        beat_d  = 2'b00;
                        state_d = ST_DECODE;
                    end
                end else if (timeout) begin
                    beat_d  = 2'b00;
                    code_d  = FAULT_FETCH_TO;
                    state_d = ST_FAULT;
                end
            end
            ST_DECODE: begin
                case (inst_type_in)
                    INST_F, INST_J: state_d = ST_UPDATE_PC;
                    INST_R:         state_d = ST_ALU_EXEC;
                    default: begin
                        case (imm_type_in)
                            IMM_LD:  state_d = ST_LOAD_MEM;
                            IMM_ST:  state_d = ST_STORE_MEM;
                            IMM_LDI: state_d = ST_UPDATE_PC;
                            default: begin
                                if (ILLEGAL_TRAP != 0) begin
                                    code_d  = FAULT_ILLEGAL;
                                    state_d = ST_FAULT;
                                end else begin
                                    state_d = ST_UPDATE_PC;
                                end
                            end
                        endcase
                    end
                endcase
            end
            ST_LOAD_MEM: state_d = ST_LOAD_MEM_WAIT;
            ST_LOAD_MEM_WAIT: begin
                if (data_read_done_in) begin
                    state_d = ST_UPDATE_PC;
                end else if (timeout) begin
                    code_d  = FAULT_LOAD_TO;
                    state_d = ST_FAULT;
                end
            end
            ST_STORE_MEM: state_d = ST_STORE_MEM_WAIT;
            ST_STORE_MEM_WAIT: begin
                if (!mem_busy_in) begin
                    state_d = ST_UPDATE_PC;
                end else if (timeout) begin
                    code_d  = FAULT_STORE_TO;
                    state_d = ST_FAULT;
                end
            end
            ST_ALU_EXEC: state_d = ST_UPDATE_PC;
            ST_UPDATE_PC: begin
                if (step_q || halt_req_in) begin
                    step_d  = 1'b0;
                    state_d = ST_HALT;
                end else if (irq_in && irq_en_in) begin
                    state_d = ST_IRQ_ENTRY;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_IRQ_ENTRY: state_d = ST_FETCH;
            ST_HALT: begin
                if (step_in) begin
                    step_d  = 1'b1;
                    state_d = ST_FETCH;
                end else if (!halt_req_in) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FAULT: begin
                if (fault_clear_in) begin
                    code_d  = FAULT_ILLEGAL;
                    state_d = ST_HALT;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // Outputs decoded purely from registered state
    always_comb begin
        seq_state_out  = state_q;
        fetch_beat_out = 2'b00;
        if ((state_q == ST_FETCH) || (state_q == ST_FETCH_WAIT)) begin
            fetch_beat_out = beat_q;
        end
        retire_out     = (state_q == ST_UPDATE_PC);
        irq_ack_out    = (state_q == ST_IRQ_ENTRY);
        halted_out     = (state_q == ST_HALT);
        fault_out      = (state_q == ST_FAULT);
        fault_code_out = code_q;
    end

endmodule

// File: tb/tb_multi_beat_sequencer.sv
// Directed bench for multi_beat_sequencer: table-driven vectors plus corner-case sequences.
// u0: 2-beat fetch, 4-cycle timeout, illegal trap on; u1: 1-beat, no timeout, trap off.
// Inputs are shared; each sequence checks only the instance it targets.
module tb_multi_beat_sequencer;
    import multi_beat_sequencer_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, busy, fd, rd, irq, ien, halt, step, fclr;
    logic [1:0] inst, imm;

    seq2_state_t st0, st1;
    logic [1:0]  beat0, beat1, code0, code1;
    logic        ret0, ret1, ack0, ack1, hlt0, hlt1, flt0, flt1;

    int checks = 0;
    int errors = 0;
    int ret_cnt = 0;

    multi_beat_sequencer #(.FETCH_BEATS(2), .TIMEOUT_CYCLES(4), .ILLEGAL_TRAP(1)) u0 (
        .clk_in(clk), .reset_in(reset), .mem_busy_in(busy), .inst_fetch_done_in(fd),
        .data_read_done_in(rd), .inst_type_in(inst), .imm_type_in(imm), .irq_in(irq),
        .irq_en_in(ien), .halt_req_in(halt), .step_in(step), .fault_clear_in(fclr),
        .seq_state_out(st0), .fetch_beat_out(beat0), .retire_out(ret0), .irq_ack_out(ack0),
        .halted_out(hlt0), .fault_out(flt0), .fault_code_out(code0));

    multi_beat_sequencer #(.FETCH_BEATS(1), .TIMEOUT_CYCLES(0), .ILLEGAL_TRAP(0)) u1 (
        .clk_in(clk), .reset_in(reset), .mem_busy_in(busy), .inst_fetch_done_in(fd),
        .data_read_done_in(rd), .inst_type_in(inst), .imm_type_in(imm), .irq_in(irq),
        .irq_en_in(ien), .halt_req_in(halt), .step_in(step), .fault_clear_in(fclr),
        .seq_state_out(st1), .fetch_beat_out(beat1), .retire_out(ret1), .irq_ack_out(ack1),
        .halted_out(hlt1), .fault_out(flt1), .fault_code_out(code1));

    typedef struct {
        logic        busy, fd, rd;
        logic [1:0]  inst, imm;
        logic        irq, ien;
        seq2_state_t st;
        logic [1:0]  beat;
        logic        ret, ack;
    } vec_t;

    vec_t tbl [0:22];

    function automatic vec_t mkv(input logic b, input logic f, input logic r,
                                 input logic [1:0] it, input logic [1:0] im,
                                 input logic q, input logic e, input seq2_state_t s,
                                 input logic [1:0] bt, input logic rt, input logic ak);
        vec_t v;
        v.busy = b; v.fd = f; v.rd = r; v.inst = it; v.imm = im; v.irq = q; v.ien = e;
        v.st = s; v.beat = bt; v.ret = rt; v.ack = ak;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (ret0) ret_cnt++;
    endtask

    task automatic clear_inputs();
        busy = 0; fd = 0; rd = 0; irq = 0; ien = 0; halt = 0; step = 0; fclr = 0;
        inst = INST_F; imm = IMM_LD;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        tick();
        reset = 0;
    endtask

    // Two fetch beats on u0, done one cycle after each FETCH; ends in DECODE
    task automatic run_fetch2();
        fd = 0; tick();
        fd = 1; tick();
        fd = 0; tick();
        fd = 1; tick();
        fd = 0;
    endtask

    task automatic chk_cleared(input string nm);
        chk({nm, "_state"}, int'(st0), int'(ST_FETCH));
        chk({nm, "_beat"}, int'(beat0), 0);
        chk({nm, "_outs"}, int'({ret0, ack0, hlt0, flt0}), 0);
        chk({nm, "_code"}, int'(code0), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clear_inputs();
        reset = 1;

        // R-type with 2-beat fetch; ST with pending IRQ; LDI with IRQ masked
        tbl[0]  = mkv(0,0,0,INST_R,IMM_LD ,0,0, ST_FETCH_WAIT,     2'd0,0,0);
        tbl[1]  = mkv(0,1,0,INST_R,IMM_LD ,0,0, ST_FETCH,          2'd1,0,0);
        tbl[2]  = mkv(0,0,0,INST_R,IMM_LD ,0,0, ST_FETCH_WAIT,     2'd1,0,0);
        tbl[3]  = mkv(0,1,0,INST_R,IMM_LD ,0,0, ST_DECODE,         2'd0,0,0);
        tbl[4]  = mkv(0,0,0,INST_R,IMM_LD ,0,0, ST_ALU_EXEC,       2'd0,0,0);
        tbl[5]  = mkv(0,0,0,INST_R,IMM_LD ,0,0, ST_UPDATE_PC,      2'd0,1,0);
        tbl[6]  = mkv(0,0,0,INST_R,IMM_LD ,0,0, ST_FETCH,          2'd0,0,0);
        tbl[7]  = mkv(0,0,0,INST_I,IMM_ST ,1,1, ST_FETCH_WAIT,     2'd0,0,0);
        tbl[8]  = mkv(0,1,0,INST_I,IMM_ST ,1,1, ST_FETCH,          2'd1,0,0);
        tbl[9]  = mkv(0,0,0,INST_I,IMM_ST ,1,1, ST_FETCH_WAIT,     2'd1,0,0);
        tbl[10] = mkv(0,1,0,INST_I,IMM_ST ,1,1, ST_DECODE,         2'd0,0,0);
        tbl[11] = mkv(0,0,0,INST_I,IMM_ST ,1,1, ST_STORE_MEM,      2'd0,0,0);
        tbl[12] = mkv(1,0,0,INST_I,IMM_ST ,1,1, ST_STORE_MEM_WAIT, 2'd0,0,0);
        tbl[13] = mkv(1,0,0,INST_I,IMM_ST ,1,1, ST_STORE_MEM_WAIT, 2'd0,0,0);
        tbl[14] = mkv(0,0,0,INST_I,IMM_ST ,1,1, ST_UPDATE_PC,      2'd0,1,0);
        tbl[15] = mkv(0,0,0,INST_I,IMM_ST ,1,1, ST_IRQ_ENTRY,      2'd0,0,1);
        tbl[16] = mkv(0,0,0,INST_I,IMM_ST ,1,1, ST_FETCH,          2'd0,0,0);
        tbl[17] = mkv(0,0,0,INST_I,IMM_LDI,1,0, ST_FETCH_WAIT,     2'd0,0,0);
        tbl[18] = mkv(0,1,0,INST_I,IMM_LDI,1,0, ST_FETCH,          2'd1,0,0);
        tbl[19] = mkv(0,0,0,INST_I,IMM_LDI,1,0, ST_FETCH_WAIT,     2'd1,0,0);
        tbl[20] = mkv(0,1,0,INST_I,IMM_LDI,1,0, ST_DECODE,         2'd0,0,0);
        tbl[21] = mkv(0,0,0,INST_I,IMM_LDI,1,0, ST_UPDATE_PC,      2'd0,1,0);
        tbl[22] = mkv(0,0,0,INST_I,IMM_LDI,1,0, ST_FETCH,          2'd0,0,0);

        // Reset state of both instances
        tick(); tick();
        chk_cleared("reset_u0");
        chk("reset_u1_state", int'(st1), int'(ST_FETCH));
        chk("reset_u1_outs", int'({beat1, ret1, ack1, hlt1, flt1, code1}), 0);
        reset = 0;

        // Table-driven vectors on u0
        for (int i = 0; i < 23; i++) begin
            busy = tbl[i].busy; fd = tbl[i].fd; rd = tbl[i].rd;
            inst = tbl[i].inst; imm = tbl[i].imm; irq = tbl[i].irq; ien = tbl[i].ien;
            tick();
            chk($sformatf("vec%0d_state", i), int'(st0), int'(tbl[i].st));
            chk($sformatf("vec%0d_beat", i), int'(beat0), int'(tbl[i].beat));
            chk($sformatf("vec%0d_retire", i), int'(ret0), int'(tbl[i].ret));
            chk($sformatf("vec%0d_irqack", i), int'(ack0), int'(tbl[i].ack));
        end

        // Load timeout: 4 wait cycles then FAULT code 10; IRQ ignored; clear goes to HALT
        do_reset();
        run_fetch2();
        inst = INST_I; imm = IMM_LD;
        tick(); chk("ld_mem", int'(st0), int'(ST_LOAD_MEM));
        tick(); repeat (3) tick();
        chk("ld_wait4", int'(st0), int'(ST_LOAD_MEM_WAIT));
        tick();
        chk("ld_to_state", int'(st0), int'(ST_FAULT));
        chk("ld_to_flag", int'(flt0), 1);
        chk("ld_to_code", int'(code0), int'(FAULT_LOAD_TO));
        irq = 1; ien = 1;
        tick();
        chk("fault_sticky", int'(st0), int'(ST_FAULT));
        chk("fault_no_ack", int'(ack0), 0);
        irq = 0; ien = 0; fclr = 1;
        tick();
        chk("fclr_state", int'(st0), int'(ST_HALT));
        chk("fclr_halted", int'(hlt0), 1);
        chk("fclr_code", int'(code0), 0);
        fclr = 0;
        tick();
        chk("halt_release", int'(st0), int'(ST_FETCH));

        // Load done exactly on the last allowed wait cycle completes normally
        do_reset();
        run_fetch2();
        inst = INST_I; imm = IMM_LD;
        tick(); tick(); repeat (3) tick();
        rd = 1;
        tick();
        chk("ld_late_state", int'(st0), int'(ST_UPDATE_PC));
        chk("ld_late_nofault", int'(flt0), 0);
        chk("ld_late_retire", int'(ret0), 1);
        rd = 0;

        // Fetch timeout gives code 01; reset in FAULT clears everything
        do_reset();
        tick(); repeat (3) tick();
        chk("fw_wait4", int'(st0), int'(ST_FETCH_WAIT));
        tick();
        chk("fw_to_state", int'(st0), int'(ST_FAULT));
        chk("fw_to_code", int'(code0), int'(FAULT_FETCH_TO));
        chk("fw_to_beat", int'(beat0), 0);
        reset = 1;
        tick();
        chk_cleared("rst_in_fault");
        reset = 0;

        // Illegal I-type traps with code 00
        do_reset();
        run_fetch2();
        inst = INST_I; imm = IMM_RSV;
        tick();
        chk("illegal_state", int'(st0), int'(ST_FAULT));
        chk("illegal_code", int'(code0), int'(FAULT_ILLEGAL));

        // Reset in STORE_MEM_WAIT
        do_reset();
        run_fetch2();
        inst = INST_I; imm = IMM_ST; busy = 1;
        tick(); tick();
        chk("st_wait", int'(st0), int'(ST_STORE_MEM_WAIT));
        reset = 1;
        tick();
        chk_cleared("rst_in_smw");
        reset = 0; busy = 0;

        // Halt held, two single steps: two retires, HALT after each
        do_reset();
        halt = 1;
        run_fetch2();
        inst = INST_F;
        tick(); tick();
        chk("halt_enter", int'(st0), int'(ST_HALT));
        tick();
        chk("halt_hold", int'(st0), int'(ST_HALT));
        ret_cnt = 0;
        for (int s = 0; s < 2; s++) begin
            step = 1; tick(); step = 0;
            chk($sformatf("step%0d_fetch", s), int'(st0), int'(ST_FETCH));
            run_fetch2();
            tick(); tick();
            chk($sformatf("step%0d_halt", s), int'(st0), int'(ST_HALT));
        end
        chk("step_retires", ret_cnt, 2);

        // Step with halt released at the same time: step flag still halts after one instruction
        step = 1; halt = 0;
        tick(); step = 0;
        run_fetch2();
        tick(); tick();
        chk("step_flag_halt", int'(st0), int'(ST_HALT));
        tick();
        chk("resume", int'(st0), int'(ST_FETCH));
        run_fetch2();
        tick(); tick();
        chk("flag_cleared", int'(st0), int'(ST_FETCH));

        // u1: no timeout when disabled, reserved imm treated as LDI
        do_reset();
        fd = 0;
        tick(); repeat (10) tick();
        chk("u1_no_timeout", int'(st1), int'(ST_FETCH_WAIT));
        chk("u1_no_fault", int'(flt1), 0);
        fd = 1;
        tick(); fd = 0;
        chk("u1_decode", int'(st1), int'(ST_DECODE));
        inst = INST_I; imm = IMM_RSV;
        tick();
        chk("u1_rsv_ldi", int'(st1), int'(ST_UPDATE_PC));
        chk("u1_rsv_retire", int'(ret1), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
